// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle arithmetic/logic, iterative shift-add MUL, bit-serial shifts.
// Latency: 1 cycle single-cycle ops and zero-length shifts; WIDTH+1 for MUL; k+1 for shifts.
// Backpressure: ALU_Start is taken only while ALU_Busy=0; requests during busy are dropped.
module alu_seq_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ALU_Start,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] ALU_Data_In1,
    input  logic [WIDTH-1:0] ALU_Data_In2,
    output logic             ALU_Busy,
    output logic             ALU_Done,
    output logic             ALU_Err,
    output logic [WIDTH-1:0] ALU_Data_Out,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = SHW + 1;
    localparam int MSB  = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_MUL = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_SRA = 4'hA;

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;      // MUL multiplicand, or shift working value
    logic [WIDTH-1:0]  lo_q, lo_d;    // MUL multiplier / low product half
    logic [WIDTH-1:0]  hi_q, hi_d;    // MUL high product half
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  out_q, out_d;
    flags_t            flg_q, flg_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [WIDTH:0]    sum_c;
    logic [WIDTH:0]    diff_c;
    logic [WIDTH:0]    mul_sum_c;
    logic [WIDTH-1:0]  mul_hi_c;
    logic [WIDTH-1:0]  mul_lo_c;
    logic [WIDTH-1:0]  sh_val_c;
    logic              sh_out_c;
    logic [SHW-1:0]    k_c;
    logic [WIDTH-1:0]  res_c;
    logic              cy_c;
    logic              ov_c;
    logic              wr_c;

    assign sum_c  = {1'b0, ALU_Data_In1} + {1'b0, ALU_Data_In2};
    assign diff_c = {1'b0, ALU_Data_In1} - {1'b0, ALU_Data_In2};
    assign k_c    = ALU_Data_In2[SHW-1:0];

    // One shift-add step: add multiplicand when multiplier LSB is set, then shift the pair right.
    assign mul_sum_c = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_hi_c  = mul_sum_c[WIDTH:1];
    assign mul_lo_c  = {mul_sum_c[0], lo_q[WIDTH-1:1]};

    always_comb begin
        sh_val_c = a_q;
        sh_out_c = 1'b0;
        case (op_q)
            OP_SHL: begin
                sh_val_c = {a_q[WIDTH-2:0], 1'b0};
                sh_out_c = a_q[MSB];
            end
            OP_SHR: begin
                sh_val_c = {1'b0, a_q[WIDTH-1:1]};
                sh_out_c = a_q[0];
            end
            OP_SRA: begin
                sh_val_c = {a_q[MSB], a_q[WIDTH-1:1]};
                sh_out_c = a_q[0];
            end
            default: begin
                sh_val_c = a_q;
                sh_out_c = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        flg_d   = flg_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        res_c   = '0;
        cy_c    = 1'b0;
        ov_c    = 1'b0;
        wr_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ALU_Start) begin
                    op_d   = ALU_Control;
                    wr_c   = 1'b1;
                    done_d = 1'b1;
                    case (ALU_Control)
                        OP_ADD: begin
                            res_c = sum_c[WIDTH-1:0];
                            cy_c  = sum_c[WIDTH];
                            ov_c  = (ALU_Data_In1[MSB] == ALU_Data_In2[MSB]) &&
                                    (sum_c[MSB] != ALU_Data_In1[MSB]);
                        end
                        OP_SUB: begin
                            res_c = diff_c[WIDTH-1:0];
                            cy_c  = ~diff_c[WIDTH];
                            ov_c  = (ALU_Data_In1[MSB] != ALU_Data_In2[MSB]) &&
                                    (diff_c[MSB] != ALU_Data_In1[MSB]);
                        end
                        OP_AND: res_c = ALU_Data_In1 & ALU_Data_In2;
                        OP_OR:  res_c = ALU_Data_In1 | ALU_Data_In2;
                        OP_XOR: res_c = ALU_Data_In1 ^ ALU_Data_In2;
                        OP_NOT: res_c = ~ALU_Data_In1;
                        OP_MOV: res_c = ALU_Data_In2;
                        OP_MUL: begin
                            wr_c    = 1'b0;
                            done_d  = 1'b0;
                            state_d = EXEC;
                            a_d     = ALU_Data_In1;
                            lo_d    = ALU_Data_In2;
                            hi_d    = '0;
                            cnt_d   = CNTW'(WIDTH);
                        end
                        OP_SHL, OP_SHR, OP_SRA: begin
                            if (k_c == '0) begin
                                res_c = ALU_Data_In1;
                            end else begin
                                wr_c    = 1'b0;
                                done_d  = 1'b0;
                                state_d = EXEC;
                                a_d     = ALU_Data_In1;
                                cnt_d   = {1'b0, k_c};
                            end
                        end
                        default: begin
                            // Illegal opcode: signal completion but keep result and flags.
                            wr_c  = 1'b0;
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNTW'(1);
                if (op_q == OP_MUL) begin
                    hi_d  = mul_hi_c;
                    lo_d  = mul_lo_c;
                    res_c = mul_lo_c;
                    cy_c  = |mul_hi_c;
                end else begin
                    a_d   = sh_val_c;
                    res_c = sh_val_c;
                    cy_c  = sh_out_c;
                end
                if (cnt_q == CNTW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    wr_c    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_c) begin
            out_d   = res_c;
            flg_d.n = res_c[MSB];
            flg_d.z = (res_c == '0);
            flg_d.c = cy_c;
            flg_d.v = ov_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            flg_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            flg_q   <= flg_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ALU_Busy     = (state_q == EXEC);
    assign ALU_Done     = done_q;
    assign ALU_Err      = err_q;
    assign ALU_Data_Out = out_q;
    assign N            = flg_q.n;
    assign Z            = flg_q.z;
    assign C            = flg_q.c;
    assign V            = flg_q.v;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit at WIDTH=16 with hand-computed results and cycle-exact timing.
module tb_alu_seq_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        ALU_Start;
    logic [3:0]  ALU_Control;
    logic [15:0] ALU_Data_In1;
    logic [15:0] ALU_Data_In2;
    logic        ALU_Busy;
    logic        ALU_Done;
    logic        ALU_Err;
    logic [15:0] ALU_Data_Out;
    logic        N, Z, C, V;
    logic [3:0]  nzcv;

    int nvec = 0;
    int nerr = 0;

    logic [3:0]  lop  [5] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    logic [15:0] lexp [5] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0F0F, 16'hFF00};
    logic [3:0]  lflg [5] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000};

    always #5 clk = ~clk;

    assign nzcv = {N, Z, C, V};

    alu_seq_unit #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ALU_Start    (ALU_Start),
        .ALU_Control  (ALU_Control),
        .ALU_Data_In1 (ALU_Data_In1),
        .ALU_Data_In2 (ALU_Data_In2),
        .ALU_Busy     (ALU_Busy),
        .ALU_Done     (ALU_Done),
        .ALU_Err      (ALU_Err),
        .ALU_Data_Out (ALU_Data_Out),
        .N            (N),
        .Z            (Z),
        .C            (C),
        .V            (V)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        ALU_Start    = 1'b1;
        ALU_Control  = op;
        ALU_Data_In1 = a;
        ALU_Data_In2 = b;
    endtask

    initial begin
        logic saw_done;
        rst          = 1'b1;
        ALU_Start    = 1'b0;
        ALU_Control  = 4'h0;
        ALU_Data_In1 = 16'h0;
        ALU_Data_In2 = 16'h0;
        tick();
        tick();
        chk("rst_out",  ALU_Data_Out, 16'h0000);
        chk("rst_nzcv", nzcv, 4'b0000);
        chk("rst_busy", ALU_Busy, 1'b0);
        chk("rst_done", ALU_Done, 1'b0);
        chk("rst_err",  ALU_Err, 1'b0);
        rst = 1'b0;
        tick();

        // ADD with signed overflow
        go(4'h0, 16'h7FFF, 16'h0001);
        tick();
        ALU_Start = 1'b0;
        chk("add_done", ALU_Done, 1'b1);
        chk("add_err",  ALU_Err, 1'b0);
        chk("add_busy", ALU_Busy, 1'b0);
        chk("add_out",  ALU_Data_Out, 16'h8000);
        chk("add_nzcv", nzcv, 4'b1001);
        tick();
        chk("add_pulse", ALU_Done, 1'b0);

        // SUB equal, then SUB with borrow issued back to back
        go(4'h1, 16'h0005, 16'h0005);
        tick();
        chk("sub0_out",  ALU_Data_Out, 16'h0000);
        chk("sub0_nzcv", nzcv, 4'b0110);
        go(4'h1, 16'h0003, 16'h0005);
        tick();
        ALU_Start = 1'b0;
        chk("sub1_done", ALU_Done, 1'b1);
        chk("sub1_out",  ALU_Data_Out, 16'hFFFE);
        chk("sub1_nzcv", nzcv, 4'b1000);

        // Logic ops back to back
        for (int i = 0; i < 5; i++) begin
            go(lop[i], 16'hF0F0, 16'hFF00);
            tick();
            chk("logic_out",  ALU_Data_Out, lexp[i]);
            chk("logic_nzcv", nzcv, lflg[i]);
        end
        ALU_Start = 1'b0;
        tick();

        // MUL 0x0100*0x0100 with an ignored start at t+3 and back-to-back ADD
        go(4'h7, 16'h0100, 16'h0100);
        tick();
        ALU_Start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk("mul_busy", ALU_Busy, 1'b1);
            chk("mul_nodone", ALU_Done, 1'b0);
            if (i == 3) go(4'h0, 16'h0001, 16'h0001);
            if (i == 4) ALU_Start = 1'b0;
            tick();
        end
        chk("mul_done", ALU_Done, 1'b1);
        chk("mul_busy_end", ALU_Busy, 1'b0);
        chk("mul_err",  ALU_Err, 1'b0);
        chk("mul_out",  ALU_Data_Out, 16'h0000);
        chk("mul_nzcv", nzcv, 4'b0110);
        go(4'h0, 16'h0003, 16'h0004);
        tick();
        ALU_Start = 1'b0;
        chk("b2b_done", ALU_Done, 1'b1);
        chk("b2b_out",  ALU_Data_Out, 16'h0007);
        chk("b2b_nzcv", nzcv, 4'b0000);

        // MUL 0x0123*0x0045 = 0x4E6F
        go(4'h7, 16'h0123, 16'h0045);
        tick();
        ALU_Start = 1'b0;
        repeat (16) tick();
        chk("mul2_done", ALU_Done, 1'b1);
        chk("mul2_out",  ALU_Data_Out, 16'h4E6F);
        chk("mul2_nzcv", nzcv, 4'b0000);

        // SHL by 1
        go(4'h8, 16'h8001, 16'h0001);
        tick();
        ALU_Start = 1'b0;
        chk("shl_busy", ALU_Busy, 1'b1);
        chk("shl_nodone", ALU_Done, 1'b0);
        tick();
        chk("shl_done", ALU_Done, 1'b1);
        chk("shl_busy_end", ALU_Busy, 1'b0);
        chk("shl_out",  ALU_Data_Out, 16'h0002);
        chk("shl_nzcv", nzcv, 4'b0010);

        // SHR by 0 (upper amount bits ignored)
        go(4'h9, 16'h1234, 16'h0010);
        tick();
        ALU_Start = 1'b0;
        chk("shr0_done", ALU_Done, 1'b1);
        chk("shr0_busy", ALU_Busy, 1'b0);
        chk("shr0_out",  ALU_Data_Out, 16'h1234);
        chk("shr0_nzcv", nzcv, 4'b0000);

        // SRA 0x8000 by 15 (amount 0x00FF -> 15)
        go(4'hA, 16'h8000, 16'h00FF);
        tick();
        ALU_Start = 1'b0;
        repeat (14) tick();
        chk("sra_busy", ALU_Busy, 1'b1);
        chk("sra_nodone", ALU_Done, 1'b0);
        tick();
        chk("sra_done", ALU_Done, 1'b1);
        chk("sra_out",  ALU_Data_Out, 16'hFFFF);
        chk("sra_nzcv", nzcv, 4'b1000);

        // Reset aborts an in-flight MUL
        go(4'h7, 16'h0003, 16'h0005);
        tick();
        ALU_Start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", ALU_Busy, 1'b0);
        chk("abort_done", ALU_Done, 1'b0);
        chk("abort_out",  ALU_Data_Out, 16'h0000);
        chk("abort_nzcv", nzcv, 4'b0000);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            tick();
            if (ALU_Done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 1'b0);
        go(4'h0, 16'h1200, 16'h0034);
        tick();
        ALU_Start = 1'b0;
        chk("post_rst_done", ALU_Done, 1'b1);
        chk("post_rst_out",  ALU_Data_Out, 16'h1234);
        chk("post_rst_nzcv", nzcv, 4'b0000);

        // Illegal opcode keeps result and flags
        go(4'h0, 16'h9234, 16'h8000);
        tick();
        chk("pre_ill_out",  ALU_Data_Out, 16'h1234);
        chk("pre_ill_nzcv", nzcv, 4'b0011);
        chk("pre_ill_err",  ALU_Err, 1'b0);
        go(4'hC, 16'hFFFF, 16'hFFFF);
        tick();
        ALU_Start = 1'b0;
        chk("ill_done", ALU_Done, 1'b1);
        chk("ill_err",  ALU_Err, 1'b1);
        chk("ill_busy", ALU_Busy, 1'b0);
        chk("ill_out",  ALU_Data_Out, 16'h1234);
        chk("ill_nzcv", nzcv, 4'b0011);
        tick();
        chk("ill_done_pulse", ALU_Done, 1'b0);
        chk("ill_err_pulse",  ALU_Err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
Parametrised-width sequential ALU, successor to the fixed 16-bit combinational ALU_16. It adds registered results and flags, and a start/busy/done handshake. It also adds multi-cycle operations: an iterative shift-add multiply and variable-amount shifts executed one bit per cycle. It sits between the register file and the writeback stage of the processor datapath.

Parameters:
WIDTH, 16, datapath width in bits; power of two, >= 4.
SHW, $clog2(WIDTH), localparam (derived, not overridable); shift-amount width.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
ALU_Start  input  1  request; accepted only when ALU_Busy=0
ALU_Control  input  4  opcode, sampled on accept
ALU_Data_In1  input  WIDTH  operand A, sampled on accept
ALU_Data_In2  input  WIDTH  operand B / shift amount, sampled on accept
ALU_Busy  output  1  multi-cycle operation in progress
ALU_Done  output  1  one-cycle pulse; result/flags valid
ALU_Err  output  1  one-cycle pulse with ALU_Done for an illegal opcode
ALU_Data_Out  output  WIDTH  registered result, held until next legal Done
N, Z, C, V  output  1 each  registered flags, held until next legal Done

Behaviour:
- One clock, clk. Reset synchronous, active-high, on rst. Reset has priority over every other event.
- Reset values: ALU_Data_Out=0, N=0, Z=0, C=0, V=0, ALU_Busy=0, ALU_Done=0, ALU_Err=0. FSM goes to IDLE.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 MOV B: single-cycle.
  - 7 MUL: multi-cycle, WIDTH iterations.
  - 8 SHL, 9 SHR logical, A SRA arithmetic: k = In2[SHW-1:0] iterations; upper bits of In2 ignored.
  - B-F: illegal.
- FSM states: IDLE, EXEC.
  - IDLE + Start (accept at cycle t): operands and opcode are latched.
  - Single-cycle op, or shift with k=0: stay in IDLE; Done=1 at t+1; Busy never asserts.
  - MUL, or shift with k>0: go to EXEC. Busy=1 for cycles t+1..t+N, where N=WIDTH for MUL and N=k for shifts.
  - Leaving EXEC: return to IDLE with Done=1 and Busy=0 at t+N+1.
- Start while Busy=1 is ignored, with no side effects.
- Start in the Done cycle is accepted (Busy=0), so back-to-back issue is supported.
- Flags, set with Done:
  - N = MSB of result; Z = (result==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = 1 if A>=B unsigned (no borrow); V = signed overflow.
  - Logic, NOT, MOV: C=0, V=0.
  - MUL: result = low WIDTH bits of the unsigned product; C = 1 if the high WIDTH bits are nonzero; V=0.
  - Shifts: C = last bit shifted out (0 when k=0); V=0. SRA replicates the MSB.
- Illegal opcode: Done=1 and Err=1 at t+1. ALU_Data_Out and flags are unchanged.
- rst during EXEC aborts the operation. No Done is issued; all outputs return to reset values on the next edge.
- Input changes after accept do not affect an in-flight operation.

Test Plan:
- WIDTH=16. ADD 0x7FFF+0x0001, Start at t -> Done at t+1, Out=0x8000, N=1 Z=0 C=0 V=1, Busy stays 0.
- SUB 0x0005-0x0005 -> Out=0x0000, Z=1, C=1, V=0. Then SUB 0x0003-0x0005 -> Out=0xFFFE, N=1, C=0.
- MUL 0x0100*0x0100, Start at t -> Busy t+1..t+16, Done at t+17, Out=0x0000, Z=1, C=1. A second Start with ADD at t+3 is ignored. ADD issued in the Done cycle completes at t+18.
- SHL 0x8001 by 1 -> Done at t+2, Out=0x0002, C=1. SRA 0x8000 by 15 -> Done at t+16, Out=0xFFFF, N=1. SHR by 0 -> Done at t+1, Out=A, C=0.
- MUL started at t, rst=1 at t+5 -> from t+6: Busy=0, Out=0, flags 0, no Done pulse. A new ADD after rst deasserts completes normally.
- Opcode 0xC after an ADD leaving Out=0x1234 -> Done=1 and Err=1 at t+1, Out stays 0x1234, flags unchanged. Err=0 on all legal Done pulses.
